// File: rtl/llc_trace_sequencer_pkg.sv
`default_nettype none
// ==========================================================================
// llc_trace_sequencer_pkg : command codes, FSM states and ratio width
// Rev 1.0
// ==========================================================================
package llc_trace_sequencer_pkg;

  localparam int RATIO_W = 14;

  typedef enum logic [3:0] {
    RD_D     = 4'd0,
    WR_D     = 4'd1,
    RD_I     = 4'd2,
    SNP_INV  = 4'd3,
    SNP_RD   = 4'd4,
    SNP_WR   = 4'd5,
    SNP_RWIM = 4'd6,
    CLR      = 4'd8,
    PRT      = 4'd9
  } trace_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DIV   = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/llc_trace_sequencer_if.sv
`default_nettype none
// ==========================================================================
// llc_trace_sequencer_if : trace command channel plus LLC request/response
// Rev 1.0
// ==========================================================================
interface llc_trace_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CMD_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd;
  logic [ADDR_W-1:0] addr;
  logic              llc_req_valid;
  logic              llc_req_ready;
  logic [CMD_W-1:0]  llc_cmd;
  logic [ADDR_W-1:0] llc_addr;
  logic              llc_resp_valid;
  logic              llc_resp_hit;

  // master: trace source and LLC model; slave: the sequencer
  modport master (
    output cmd_valid, cmd, addr, llc_req_ready, llc_resp_valid, llc_resp_hit,
    input  cmd_ready, llc_req_valid, llc_cmd, llc_addr
  );

  modport slave (
    input  cmd_valid, cmd, addr, llc_req_ready, llc_resp_valid, llc_resp_hit,
    output cmd_ready, llc_req_valid, llc_cmd, llc_addr
  );
endinterface
`default_nettype wire

// File: rtl/llc_trace_sequencer_seq_divider.sv
`default_nettype none
// ==========================================================================
// llc_trace_sequencer_seq_divider : unsigned restoring divider, 1 bit/cycle
// Rev 1.0
// ==========================================================================
module llc_trace_sequencer_seq_divider #(
  parameter int N_W = 46,
  parameter int D_W = 33,
  parameter int Q_W = 14
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           i_start,
  input  wire logic [N_W-1:0] i_num,
  input  wire logic [D_W-1:0] i_den,
  output logic                o_done,
  output logic [Q_W-1:0]      o_quo
);
  localparam int c_CNT_W = $clog2(N_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [D_W-1:0]     r_rem;
  logic [D_W-1:0]     r_den;
  logic [N_W-1:0]     r_quo;
  logic [c_CNT_W-1:0] r_cnt;
  logic [D_W:0]       w_shift;
  logic               w_ge;
  logic [D_W-1:0]     w_diff;
  logic [D_W-1:0]     w_rem_next;
  logic [N_W-1:0]     w_quo_next;

  // remainder stays below the divisor, so the modular subtract is exact when w_ge
  assign w_shift    = {r_rem, r_quo[N_W-1]};
  assign w_ge       = w_shift >= {1'b0, r_den};
  assign w_diff     = w_shift[D_W-1:0] - r_den;
  assign w_rem_next = w_ge ? w_diff : w_shift[D_W-1:0];
  assign w_quo_next = {r_quo[N_W-2:0], w_ge};

  // o_done marks the cycle whose closing edge completes the quotient
  assign o_done = (r_cnt == c_CNT_ONE);
  assign o_quo  = w_quo_next[Q_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_den <= '0;
      r_quo <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_den <= i_den;
      r_quo <= i_num;
      r_cnt <= c_CNT_W'(N_W);
    end else if (r_cnt != '0) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt - c_CNT_ONE;
    end
  end
endmodule
`default_nettype wire

// File: rtl/llc_trace_sequencer.sv
`default_nettype none
// ==========================================================================
// llc_trace_sequencer : issues trace commands to the LLC, keeps statistics
// Rev 1.0
// ==========================================================================
module llc_trace_sequencer
  import llc_trace_sequencer_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int CMD_W        = 4,
  parameter int CNT_W        = 32,
  parameter int RESP_TIMEOUT = 64,
  parameter int RATIO_SCALE  = 10000
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_mode,
  llc_trace_sequencer_if.slave bus,
  input  wire logic            i_ratio_req,
  output logic                 o_ratio_valid,
  output logic [RATIO_W-1:0]   o_ratio_out,
  output logic                 o_report_pulse,
  output logic [CNT_W-1:0]     o_reads,
  output logic [CNT_W-1:0]     o_writes,
  output logic [CNT_W-1:0]     o_hits,
  output logic [CNT_W-1:0]     o_misses,
  output logic [CNT_W-1:0]     o_errors,
  output logic                 o_busy
);
  localparam int c_NUM_W = CNT_W + RATIO_W;
  localparam int c_DEN_W = CNT_W + 1;
  localparam int c_TMR_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
  localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);
  localparam logic [c_NUM_W-1:0] c_SCALE    = c_NUM_W'(RATIO_SCALE);

  seq_state_e          r_state;
  logic                r_pend;
  logic                r_zero;
  logic                r_rw;
  logic                r_req_valid;
  logic [CMD_W-1:0]    r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_TMR_W-1:0]  r_timer;
  logic                r_report;
  logic                r_ratio_valid;
  logic [RATIO_W-1:0]  r_ratio_out;
  logic [CNT_W-1:0]    r_reads, r_writes, r_hits, r_misses, r_errors;
  logic [c_DEN_W-1:0]  w_den;
  logic [c_NUM_W-1:0]  w_num;
  logic                w_div_start;
  logic                w_div_done;
  logic [RATIO_W-1:0]  w_quo;
  logic                w_fwd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + c_CNT_ONE;
  endfunction

  assign w_den       = {1'b0, r_hits} + {1'b0, r_misses};
  assign w_num       = c_NUM_W'(r_hits) * c_SCALE;
  // divider is loaded on the same edge that enters DIV; empty denominator skips it
  assign w_div_start = (r_state == ST_IDLE) && r_pend && (w_den != '0);
  assign w_fwd       = (bus.cmd <= CMD_W'(SNP_RWIM));

  llc_trace_sequencer_seq_divider #(
    .N_W (c_NUM_W),
    .D_W (c_DEN_W),
    .Q_W (RATIO_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (w_den),
    .o_done  (w_div_done),
    .o_quo   (w_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pend        <= 1'b0;
      r_zero        <= 1'b0;
      r_rw          <= 1'b0;
      r_req_valid   <= 1'b0;
      r_cmd         <= '0;
      r_addr        <= '0;
      r_timer       <= '0;
      r_report      <= 1'b0;
      r_ratio_valid <= 1'b0;
      r_ratio_out   <= '0;
      r_reads       <= '0;
      r_writes      <= '0;
      r_hits        <= '0;
      r_misses      <= '0;
      r_errors      <= '0;
    end else begin
      r_report      <= 1'b0;
      r_ratio_valid <= 1'b0;
      r_pend        <= r_pend | i_ratio_req;
      case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            r_state <= ST_DIV;
            r_zero  <= (w_den == '0);
          end else if (bus.cmd_valid) begin
            if (w_fwd) begin
              r_state     <= ST_ISSUE;
              r_req_valid <= 1'b1;
              r_cmd       <= bus.cmd;
              r_addr      <= bus.addr;
              r_rw        <= (bus.cmd <= CMD_W'(RD_I));
            end
            case (bus.cmd)
              RD_D, RD_I: r_reads  <= sat_inc(r_reads);
              WR_D:       r_writes <= sat_inc(r_writes);
              SNP_INV, SNP_RD, SNP_WR, SNP_RWIM: ;
              CLR: begin
                r_reads  <= '0;
                r_writes <= '0;
                r_hits   <= '0;
                r_misses <= '0;
                r_errors <= '0;
              end
              PRT:     r_report <= ~i_mode;
              default: r_errors <= sat_inc(r_errors);
            endcase
          end
        end
        ST_ISSUE: begin
          if (bus.llc_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_WAIT;
            r_timer     <= '0;
          end
        end
        ST_WAIT: begin
          // a response on the expiry cycle wins over the timeout
          if (bus.llc_resp_valid) begin
            r_state <= ST_IDLE;
            if (r_rw) begin
              if (bus.llc_resp_hit) r_hits   <= sat_inc(r_hits);
              else                  r_misses <= sat_inc(r_misses);
            end
          end else if (r_timer == c_TMR_LAST) begin
            r_state  <= ST_IDLE;
            r_errors <= sat_inc(r_errors);
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end
        ST_DIV: begin
          if (r_zero || w_div_done) begin
            r_ratio_valid <= 1'b1;
            r_ratio_out   <= r_zero ? '0 : w_quo;
            r_state       <= ST_IDLE;
            r_pend        <= i_ratio_req;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = (r_state == ST_IDLE) && !r_pend;
  assign bus.llc_req_valid = r_req_valid;
  assign bus.llc_cmd       = r_cmd;
  assign bus.llc_addr      = r_addr;
  assign o_busy            = (r_state != ST_IDLE) || r_pend;
  assign o_report_pulse    = r_report;
  assign o_ratio_valid     = r_ratio_valid;
  assign o_ratio_out       = r_ratio_out;
  assign o_reads           = r_reads;
  assign o_writes          = r_writes;
  assign o_hits            = r_hits;
  assign o_misses          = r_misses;
  assign o_errors          = r_errors;
endmodule
`default_nettype wire

// File: tb/tb_llc_trace_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_llc_trace_sequencer : scenario tasks against a counter/ratio model
// Rev 1.0
// ==========================================================================
module tb_llc_trace_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        ratio_req = 1'b0;
  logic        ratio_valid;
  logic [13:0] ratio_out;
  logic        report_pulse;
  logic [31:0] reads, writes, hits, misses, errors;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_reads, m_writes, m_hits, m_misses, m_errors;

  localparam int DIV_LAT = 2 + 32 + 14;

  always #5 clk = ~clk;

  llc_trace_sequencer_if #(.ADDR_W(32), .CMD_W(4)) bus ();

  llc_trace_sequencer dut (
    .clk(clk), .rst(rst), .i_mode(mode), .bus(bus), .i_ratio_req(ratio_req),
    .o_ratio_valid(ratio_valid), .o_ratio_out(ratio_out), .o_report_pulse(report_pulse),
    .o_reads(reads), .o_writes(writes), .o_hits(hits), .o_misses(misses),
    .o_errors(errors), .o_busy(busy)
  );

  function automatic void model_clear();
    m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0; m_errors = 0;
  endfunction

  function automatic void model_accept(input int c);
    if (c == 0 || c == 2) m_reads++;
    else if (c == 1) m_writes++;
    else if (c == 8) model_clear();
    else if (c == 7 || c > 9) m_errors++;
  endfunction

  function automatic void model_resp(input int c, input bit hit);
    if (c <= 2) begin
      if (hit) m_hits++;
      else     m_misses++;
    end
  endfunction

  function automatic int model_ratio();
    longint h = longint'(m_hits);
    longint t = longint'(m_hits) + longint'(m_misses);
    if (t == 0) return 0;
    return int'((h * 10000) / t);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd = '0; bus.addr = '0;
    bus.llc_req_ready = 1'b0; bus.llc_resp_valid = 1'b0; bus.llc_resp_hit = 1'b0;
    ratio_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_clear();
  endtask

  // returns on the negedge following the acceptance edge
  task automatic send_cmd(input logic [3:0] c, input logic [31:0] a);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd = c; bus.addr = a;
    while (bus.cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vectors++; miscompares++;
      $display("FAIL send_cmd_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_access(input int c, input logic [31:0] a, input bit hit,
                           input int rdy_dly, input int resp_dly);
    send_cmd(4'(c), a);
    model_accept(c);
    repeat (rdy_dly) @(negedge clk);
    bus.llc_req_ready = 1'b1;
    @(negedge clk);
    bus.llc_req_ready = 1'b0;
    repeat (resp_dly) @(negedge clk);
    bus.llc_resp_valid = 1'b1; bus.llc_resp_hit = hit;
    @(negedge clk);
    bus.llc_resp_valid = 1'b0; bus.llc_resp_hit = 1'b0;
    model_resp(c, hit);
  endtask

  // lat = negedges from the request pulse to the ratio_valid sample
  task automatic run_ratio(output int val, output int lat);
    ratio_req = 1'b1;
    @(negedge clk);
    ratio_req = 1'b0;
    lat = 1;
    while (ratio_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    val = int'(ratio_out);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({reads, writes, hits, misses, errors} !== 160'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d/%0d/%0d/%0d required all 0", reads, writes, hits, misses, errors);
    end
    vectors++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.llc_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready=%b busy=%b req_valid=%b required 1/0/0", bus.cmd_ready, busy, bus.llc_req_valid);
    end
    vectors++;
    if (ratio_valid !== 1'b0 || ratio_out !== 14'd0 || report_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ratio: valid=%b out=%0d report=%b required 0/0/0", ratio_valid, ratio_out, report_pulse);
    end
  endtask

  task automatic test_zero_denominator();
    int val, lat;
    run_ratio(val, lat);
    vectors++;
    if (lat != 3 || val != 0) begin
      miscompares++;
      $display("FAIL zero_den: latency=%0d ratio=%0d required 3/0", lat, val);
    end
    @(negedge clk);
    vectors++;
    if (ratio_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_den_pulse: valid=%b busy=%b required 0/0", ratio_valid, busy);
    end
  endtask

  task automatic test_hit_miss();
    int val, lat;
    do_access(0, $urandom, 1'b1, 0, 2);
    do_access(0, $urandom, 1'b1, 1, 0);
    do_access(0, $urandom, 1'b0, 0, 5);
    do_access(1, $urandom, 1'b1, 2, 1);
    vectors++;
    if (reads !== 32'd3 || writes !== 32'd1 || hits !== 32'd3 || misses !== 32'd1 || errors !== 32'd0) begin
      miscompares++;
      $display("FAIL hit_miss_counts: got r=%0d w=%0d h=%0d m=%0d e=%0d required 3/1/3/1/0", reads, writes, hits, misses, errors);
    end
    run_ratio(val, lat);
    vectors++;
    if (val != 7500 || lat != DIV_LAT) begin
      miscompares++;
      $display("FAIL hit_miss_ratio: ratio=%0d latency=%0d required 7500/%0d", val, lat, DIV_LAT);
    end
    @(negedge clk);
    vectors++;
    if (ratio_valid !== 1'b0 || ratio_out !== 14'd7500) begin
      miscompares++;
      $display("FAIL ratio_hold: valid=%b out=%0d required 0/7500", ratio_valid, ratio_out);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    int bad = 0;
    a = $urandom;
    send_cmd(4'd1, a);
    model_accept(1);
    repeat (6) begin
      if (bus.llc_req_valid !== 1'b1 || bus.llc_cmd !== 4'd1 || bus.llc_addr !== a) bad++;
      @(negedge clk);
    end
    bus.llc_req_ready = 1'b1;
    @(negedge clk);
    bus.llc_req_ready = 1'b0;
    vectors++;
    if (bad != 0 || bus.llc_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure: unstable_cycles=%0d req_valid_after=%b required 0/0", bad, bus.llc_req_valid);
    end
    bus.llc_resp_valid = 1'b1; bus.llc_resp_hit = 1'b0;
    @(negedge clk);
    bus.llc_resp_valid = 1'b0;
    model_resp(1, 1'b0);
  endtask

  task automatic test_misc_cmds();
    mode = 1'b0;
    send_cmd(4'd9, $urandom);
    vectors++;
    if (report_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL report_mode0: pulse=%b required 1", report_pulse);
    end
    @(negedge clk);
    vectors++;
    if (report_pulse !== 1'b0 || bus.llc_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL report_width: pulse=%b req_valid=%b required 0/0", report_pulse, bus.llc_req_valid);
    end
    mode = 1'b1;
    send_cmd(4'd9, $urandom);
    vectors++;
    if (report_pulse !== 1'b0 || bus.llc_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL report_mode1: pulse=%b req_valid=%b required 0/0", report_pulse, bus.llc_req_valid);
    end
    mode = 1'b0;
    send_cmd(4'd7, $urandom);
    model_accept(7);
    send_cmd(4'd12, $urandom);
    model_accept(12);
    vectors++;
    if (errors !== m_errors || bus.llc_req_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL invalid_cmd: errors=%0d req_valid=%b ready=%b required %0d/0/1", errors, bus.llc_req_valid, bus.cmd_ready, m_errors);
    end
    send_cmd(4'd8, $urandom);
    model_accept(8);
    vectors++;
    if ({reads, writes, hits, misses, errors} !== 160'd0 || bus.llc_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_cmd: got %0d/%0d/%0d/%0d/%0d req_valid=%b required all 0", reads, writes, hits, misses, errors, bus.llc_req_valid);
    end
  endtask

  task automatic test_timeout();
    int k;
    send_cmd(4'd2, $urandom);
    model_accept(2);
    bus.llc_req_ready = 1'b1;
    @(negedge clk);
    bus.llc_req_ready = 1'b0;
    k = 1;
    while (bus.cmd_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    m_errors++;
    vectors++;
    if (k != 65) begin
      miscompares++;
      $display("FAIL timeout_latency: idle after %0d cycles required 65", k);
    end
    vectors++;
    if (errors !== m_errors || hits !== m_hits || misses !== m_misses || reads !== m_reads) begin
      miscompares++;
      $display("FAIL timeout_counts: e=%0d h=%0d m=%0d r=%0d required %0d/%0d/%0d/%0d", errors, hits, misses, reads, m_errors, m_hits, m_misses, m_reads);
    end
    do_access(0, $urandom, 1'b1, 0, 63);
    vectors++;
    if (hits !== m_hits || errors !== m_errors || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_edge_resp: h=%0d e=%0d ready=%b required %0d/%0d/1", hits, errors, bus.cmd_ready, m_hits, m_errors);
    end
  endtask

  task automatic test_priority();
    logic [31:0] a2;
    int n = 0;
    int bad = 0;
    a2 = $urandom;
    send_cmd(4'd0, $urandom);
    model_accept(0);
    bus.llc_req_ready = 1'b1;
    @(negedge clk);
    bus.llc_req_ready = 1'b0;
    ratio_req = 1'b1;
    @(negedge clk);
    ratio_req = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd = 4'd1; bus.addr = a2;
    repeat (3) begin
      if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    bus.llc_resp_valid = 1'b1; bus.llc_resp_hit = 1'b1;
    @(negedge clk);
    bus.llc_resp_valid = 1'b0; bus.llc_resp_hit = 1'b0;
    model_resp(0, 1'b1);
    while (ratio_valid !== 1'b1 && n < 200) begin
      if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bad != 0 || n >= 200) begin
      miscompares++;
      $display("FAIL prio_hold: busy/ready violations=%0d wait=%0d required 0 and <200", bad, n);
    end
    vectors++;
    if (int'(ratio_out) != model_ratio() || writes !== m_writes || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_ratio: ratio=%0d writes=%0d ready=%b required %0d/%0d/1", ratio_out, writes, bus.cmd_ready, model_ratio(), m_writes);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    model_accept(1);
    vectors++;
    if (bus.llc_req_valid !== 1'b1 || bus.llc_cmd !== 4'd1 || bus.llc_addr !== a2) begin
      miscompares++;
      $display("FAIL prio_release: req_valid=%b cmd=%0d addr=%h required 1/1/%h", bus.llc_req_valid, bus.llc_cmd, bus.llc_addr, a2);
    end
    bus.llc_req_ready = 1'b1;
    @(negedge clk);
    bus.llc_req_ready = 1'b0;
    bus.llc_resp_valid = 1'b1; bus.llc_resp_hit = 1'b0;
    @(negedge clk);
    bus.llc_resp_valid = 1'b0;
    model_resp(1, 1'b0);
    vectors++;
    if (writes !== m_writes || misses !== m_misses || hits !== m_hits) begin
      miscompares++;
      $display("FAIL prio_counts: w=%0d h=%0d m=%0d required %0d/%0d/%0d", writes, hits, misses, m_writes, m_hits, m_misses);
    end
  endtask

  task automatic test_random();
    int r, c, val, lat, exp_lat;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        c = $urandom_range(0, 6);
        do_access(c, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 12));
      end else if (r < 80) begin
        c = (r < 75) ? 7 : $urandom_range(10, 15);
        send_cmd(4'(c), $urandom);
        model_accept(c);
      end else if (r < 83) begin
        send_cmd(4'd8, $urandom);
        model_accept(8);
      end else if (r < 90) begin
        mode = 1'($urandom_range(0, 1));
        send_cmd(4'd9, $urandom);
        vectors++;
        if (report_pulse !== ~mode) begin
          miscompares++;
          $display("FAIL rand_report iter %0d: pulse=%b required %b", it, report_pulse, ~mode);
        end
        mode = 1'b0;
      end else begin
        exp_lat = (m_hits + m_misses == 0) ? 3 : DIV_LAT;
        run_ratio(val, lat);
        vectors++;
        if (val != model_ratio() || lat != exp_lat) begin
          miscompares++;
          $display("FAIL rand_ratio iter %0d: ratio=%0d latency=%0d required %0d/%0d", it, val, lat, model_ratio(), exp_lat);
        end
      end
      vectors++;
      if ({reads, writes, hits, misses, errors} !== {m_reads, m_writes, m_hits, m_misses, m_errors}) begin
        miscompares++;
        $display("FAIL rand_counters iter %0d: got r=%0d w=%0d h=%0d m=%0d e=%0d required %0d/%0d/%0d/%0d/%0d",
                 it, reads, writes, hits, misses, errors, m_reads, m_writes, m_hits, m_misses, m_errors);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    send_cmd(4'd0, $urandom);
    model_accept(0);
    bus.llc_req_ready = 1'b1;
    @(negedge clk);
    bus.llc_req_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if ({reads, writes, hits, misses, errors} !== 160'd0 || bus.llc_req_valid !== 1'b0 ||
        bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: r=%0d req_valid=%b ready=%b busy=%b required 0/0/1/0", reads, bus.llc_req_valid, bus.cmd_ready, busy);
    end
    bus.llc_resp_valid = 1'b1; bus.llc_resp_hit = 1'b1;
    @(negedge clk);
    bus.llc_resp_valid = 1'b0; bus.llc_resp_hit = 1'b0;
    vectors++;
    if (hits !== 32'd0 || misses !== 32'd0) begin
      miscompares++;
      $display("FAIL stray_resp: h=%0d m=%0d required 0/0", hits, misses);
    end
  endtask

  initial begin
    test_reset();
    test_zero_denominator();
    test_hit_miss();
    test_backpressure();
    test_misc_cmds();
    test_timeout();
    test_priority();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
